// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcodes, memory geometry
// and the program loader state encoding.
package cpu_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_INST_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 16;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_LD   = 5'b01000;
  localparam logic [4:0] OP_ST   = 5'b01001;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_JMP  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 27;
  localparam int DEST_MSB = 26;
  localparam int DEST_LSB = 22;
  localparam int SRC1_MSB = 21;
  localparam int SRC1_LSB = 17;
  localparam int MODE_BIT = 16;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  // Assembles one instruction; mode selects src2 register vs immediate in the low half.
  function automatic logic [31:0] mkInst(input logic [4:0] op, input logic [4:0] dest,
                                         input logic [4:0] src1, input logic mode,
                                         input logic [15:0] imm);
    return {op, dest, src1, mode, imm};
  endfunction

  localparam logic [31:0] HALT_INST = {OP_HALT, 27'd0};

  typedef enum logic [3:0] {
    LD_IDLE,
    LD_HDR,
    LD_HI,
    LD_LO,
    LD_WRITE,
    LD_FILL,
    LD_CHK,
    LD_DONE,
    LD_ERR
  } ldState_e;

endpackage

// File: rtl/prog_loader_xor.sv
// Running XOR of accepted stream words, used to validate the program checksum.
module prog_loader_xor #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q ^ din;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a framed program stream into instruction memory, pads the remainder with
// HALT and releases the CPU reset only after a matching checksum.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int INST_W = DEF_INST_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [INST_W-1:0] im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  ldState_e state_q, state_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [ADDR_W:0] n_q, n_d;
  logic [WORD_W-1:0] hi_q, hi_d;

  logic in_ready_q, in_ready_d;
  logic im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [INST_W-1:0] im_wdata_q, im_wdata_d;
  logic cpu_rst_q, cpu_rst_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic xfer;
  logic accClr;
  logic accEn;
  logic [ADDR_W:0] hdrN;
  logic [WORD_W-1:0] acc;

  assign xfer = in_valid && in_ready_q;
  assign hdrN = in_data[ADDR_W:0];

  prog_loader_xor #(.W(WORD_W)) u_xor (
    .clk (clk),
    .rst (sys_rst),
    .clr (accClr),
    .en  (accEn),
    .din (in_data),
    .acc (acc)
  );

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= LD_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      hi_q       <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      hi_q       <= hi_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    hi_d    = hi_q;
    accClr  = 1'b0;
    accEn   = 1'b0;

    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d = LD_HDR;
          idx_d   = '0;
          accClr  = 1'b1;
        end
      end
      LD_HDR: begin
        if (xfer) begin
          n_d   = hdrN;
          accEn = 1'b1;
          if (hdrN == '0 || hdrN > DEPTH_C) state_d = LD_ERR;
          else                              state_d = LD_HI;
        end
      end
      LD_HI: begin
        if (xfer) begin
          hi_d    = in_data;
          accEn   = 1'b1;
          state_d = LD_LO;
        end
      end
      LD_LO: begin
        if (xfer) begin
          accEn   = 1'b1;
          state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        idx_d = idx_q + ONE_C;
        if (idx_d == n_q) state_d = (n_q < DEPTH_C) ? LD_FILL : LD_CHK;
        else              state_d = LD_HI;
      end
      LD_FILL: begin
        idx_d = idx_q + ONE_C;
        if (idx_q == LAST_C) state_d = LD_CHK;
      end
      LD_CHK: begin
        // The checksum word itself never enters the accumulator.
        if (xfer) state_d = (in_data == acc) ? LD_DONE : LD_ERR;
      end
      default: state_d = LD_IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight off a flop.
    in_ready_d = state_d inside {LD_HDR, LD_HI, LD_LO, LD_CHK};
    busy_d     = !(state_d inside {LD_IDLE, LD_DONE, LD_ERR});
    done_d     = (state_d == LD_DONE);
    err_d      = (state_d == LD_ERR);
    cpu_rst_d  = (state_d != LD_DONE);
    im_we_d    = state_d inside {LD_WRITE, LD_FILL};
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    if (state_d == LD_WRITE) begin
      im_addr_d  = idx_d[ADDR_W-1:0];
      im_wdata_d = {hi_q, in_data};
    end else if (state_d == LD_FILL) begin
      im_addr_d  = idx_d[ADDR_W-1:0];
      im_wdata_d = HALT_INST;
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a stream-level model predicts every memory
// write and the final status, and a monitor checks the DUT each cycle.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        im_we;
  logic [3:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader dut (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         expWr[$];
  logic [15:0] stream[$];
  logic        expDone;
  logic        expErr;
  logic        allowStart = 1'b0;
  logic        firstSeen = 1'b0;
  logic [47:0] firstWr = '0;

  task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected writes and status derived purely from the stream contents.
  task automatic buildExpect();
    int n;
    logic [15:0] x;
    wr_t w;
    expWr.delete();
    n = int'(stream[0][4:0]);
    expDone = 1'b0;
    expErr  = 1'b0;
    if (n == 0 || n > 16) begin
      expErr = 1'b1;
    end else begin
      x = 16'h0;
      for (int k = 0; k <= 2 * n; k++) x = x ^ stream[k];
      for (int i = 0; i < 16; i++) begin
        w.addr = i[3:0];
        w.data = (i < n) ? {stream[1 + 2 * i], stream[2 + 2 * i]} : 32'hD800_0000;
        expWr.push_back(w);
      end
      expDone = (stream[2 * n + 1] == x);
      expErr  = !expDone;
    end
  endtask

  task automatic makeProgram(input int n, input bit corrupt);
    logic [15:0] x;
    logic [15:0] wd;
    stream.delete();
    wd = {11'($urandom), 5'(n)};
    stream.push_back(wd);
    if (n >= 1 && n <= 16) begin
      x = wd;
      for (int k = 0; k < 2 * n; k++) begin
        wd = 16'($urandom);
        stream.push_back(wd);
        x = x ^ wd;
      end
      if (corrupt) x = x ^ (16'h1 << $urandom_range(0, 15));
      stream.push_back(x);
    end
  endtask

  task automatic pulseStart();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 48'({busy, cpu_rst, done, err}), 48'(4'b1100));
  endtask

  task automatic sendWord(input logic [15:0] w, input bit isLo);
    int  stalls;
    bit  ok;
    stalls = $urandom_range(0, 2);
    repeat (stalls) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      start    = allowStart && ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      start    = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = w;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("word_accepted", 48'(ok), 48'(1));
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    if (isLo) begin
      @(negedge clk);
      checkOutput("lo_latency_we", 48'({in_ready, im_we}), 48'(2'b01));
    end
  endtask

  task automatic applyStimulus(input bit stallStart);
    int  n;
    int  last;
    bit  got;
    firstSeen = 1'b0;
    pulseStart();
    allowStart = stallStart;
    n = int'(stream[0][4:0]);
    last = (n == 0 || n > 16) ? 1 : stream.size();
    for (int k = 0; k < last; k++) sendWord(stream[k], (k >= 2) && (k % 2 == 0) && (k <= 2 * n));
    allowStart = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done || err) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("load_finished", 48'(got), 48'(1));
    checkOutput("final_flags", 48'({done, err, cpu_rst, busy}), 48'({expDone, expErr, !expDone, 1'b0}));
    checkOutput("writes_left", 48'(expWr.size()), 48'(0));
  endtask

  always @(negedge clk) begin : monitor
    wr_t w;
    if (sys_rst === 1'b0) begin
      checkOutput("cpu_rst_vs_done", 48'(cpu_rst), 48'(done ? 1'b0 : 1'b1));
      if (im_we) begin
        checkOutput("ready_low_on_write", 48'(in_ready), 48'(0));
        if (!firstSeen) begin
          firstWr   = 48'({im_addr, im_wdata});
          firstSeen = 1'b1;
        end
        if (expWr.size() == 0) begin
          checkOutput("unexpected_write", 48'({im_addr, im_wdata}), 48'hFFFF_FFFF_FFFF);
        end else begin
          w = expWr.pop_front();
          checkOutput("write_addr_data", 48'({im_addr, im_wdata}), 48'({w.addr, w.data}));
        end
      end
    end
  end

  localparam logic [47:0] RESET_VEC = 48'({1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});

  initial begin
    int  n;
    bit  corrupt;
    sys_rst  = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_values", 48'({in_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, err}), RESET_VEC);
    sys_rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_values", 48'({in_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, err}), RESET_VEC);

    $display("[TB] single instruction");
    stream = '{16'h0001, 16'h0841, 16'h0005, 16'h0845};
    buildExpect();
    checkOutput("model_first_write", 48'({expWr[0].addr, expWr[0].data}), 48'({4'h0, 32'h0841_0005}));
    checkOutput("model_last_write", 48'({expWr[15].addr, expWr[15].data}), 48'({4'hF, 32'hD800_0000}));
    checkOutput("model_write_count", 48'(expWr.size()), 48'(16));
    checkOutput("model_done", 48'({expDone, expErr}), 48'(2'b10));
    applyStimulus(1'b0);
    checkOutput("first_write_literal", firstWr, 48'({4'h0, 32'h0841_0005}));
    checkOutput("single_status_literal", 48'({done, err, cpu_rst}), 48'(3'b100));

    $display("[TB] full program");
    makeProgram(16, 1'b0);
    buildExpect();
    applyStimulus(1'b0);

    $display("[TB] bad checksum");
    stream = '{16'h0001, 16'h0841, 16'h0005, 16'h0846};
    buildExpect();
    checkOutput("model_bad_checksum", 48'({expDone, expErr}), 48'(2'b01));
    applyStimulus(1'b0);
    checkOutput("badck_status_literal", 48'({done, err, cpu_rst}), 48'(3'b011));

    $display("[TB] bad headers");
    stream = '{16'h0000};
    buildExpect();
    applyStimulus(1'b0);
    stream = '{16'h0011};
    buildExpect();
    applyStimulus(1'b0);

    $display("[TB] stalls with start pulses");
    stream = '{16'h0001, 16'h0841, 16'h0005, 16'h0845};
    buildExpect();
    applyStimulus(1'b1);
    checkOutput("stall_first_write", firstWr, 48'({4'h0, 32'h0841_0005}));

    $display("[TB] reset mid-load");
    makeProgram(5, 1'b0);
    buildExpect();
    pulseStart();
    sendWord(stream[0], 1'b0);
    sendWord(stream[1], 1'b0);
    sendWord(stream[2], 1'b1);
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("midload_reset_values",
                48'({in_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, err}), RESET_VEC);
    expWr.delete();
    @(posedge clk); #1;
    sys_rst = 1'b0;
    makeProgram(16, 1'b0);
    buildExpect();
    applyStimulus(1'b1);

    $display("[TB] random loads");
    repeat (10) begin
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
      corrupt = ($urandom_range(0, 3) == 0);
      makeProgram(n, corrupt);
      buildExpect();
      applyStimulus(1'b1);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the CPU's 16-entry x 32-bit instruction memory; replaces the simulation-only file preload with a loadable path.
- Accepts a framed program stream over a 16-bit valid/ready bus: header, instruction halves, XOR checksum.
- Writes each assembled instruction into instruction memory and pads unused entries with HALT.
- Holds the CPU in reset until the load completes with a good checksum.

Parameters:
- WORD_W, 16, width of the input stream word
- INST_W, 32, instruction width (2 x WORD_W)
- ADDR_W, 4, instruction memory address width
- DEPTH, 16, instruction memory entries

Ports:
- clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERR only
- in_valid  in  1  stream word valid
- in_data  in  WORD_W  stream word
- in_ready  out  1  loader can accept a word; a transfer occurs on in_valid && in_ready at a clk edge
- im_we  out  1  instruction memory write enable
- im_addr  out  ADDR_W  instruction memory write address
- im_wdata  out  INST_W  instruction memory write data
- cpu_rst  out  1  CPU reset hold; high whenever a valid program is not resident
- busy  out  1  load in progress
- done  out  1  last load succeeded; held high until the next start
- err  out  1  last load failed; held high until the next start

Behaviour:
- Reset: asynchronous, active-high. State = IDLE. Output values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, busy=0, done=0, err=0.
- Reset mid-load: same reset values; partially written memory contents are don't-care.
- All outputs are registered.
- Stream format:
  - Header word: N in bits [4:0], bits [15:5] ignored.
  - Then N instructions, each as two words: bits [31:16] first, then bits [15:0].
  - Then one checksum word = XOR of the header and all 2N instruction words.
- States:
  - IDLE: in_ready=0. On start, clear done/err, set busy=1, cpu_rst=1, clear idx and accumulator, go to HDR.
  - HDR: in_ready=1. On transfer, capture N and XOR it into the accumulator.
    - N==0 or N>DEPTH: go to ERR.
    - Otherwise: go to HI.
  - HI: in_ready=1. On transfer, latch hi, XOR into accumulator, go to LO.
  - LO: in_ready=1. On transfer, XOR into accumulator, go to WRITE.
  - WRITE (one cycle): in_ready=0, im_we=1, im_addr=idx, im_wdata={hi,lo}. Then idx++.
    - New idx==N and N<DEPTH: go to FILL.
    - New idx==N and N==DEPTH: go to CHK.
    - Otherwise: go to HI.
  - FILL: in_ready=0, one write per cycle. im_we=1, im_addr=idx, im_wdata=HALT_INST (32'hD800_0000, opcode 5'b11011 in bits [31:27], remaining bits 0).
    - idx increments each cycle.
    - After the write to DEPTH-1, go to CHK.
    - Takes DEPTH-N cycles.
  - CHK: in_ready=1. On transfer, compare the word with the accumulator.
    - Equal: go to DONE.
    - Not equal: go to ERR.
  - DONE: busy=0, done=1, cpu_rst=0. On start, go to HDR with cpu_rst=1 on the next cycle.
  - ERR: busy=0, err=1, cpu_rst=1. On start, go to HDR.
- Latency: LO transfer at edge k gives an im_we pulse exactly one cycle wide in the cycle after edge k. There are no back-to-back words at in_ready during WRITE.
- in_data is never sampled without in_ready. in_valid held low stalls any accepting state indefinitely without timeout.
- start while busy=1 is ignored.
- im_we is 0 in every state other than WRITE and FILL. im_addr/im_wdata hold their last value when im_we=0.
- idx is ADDR_W+1 bits wide so N==DEPTH is comparable without wrap.
- The accumulator is a 16-bit XOR. It updates only on accepted header and data words, never on the checksum word.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants, including OP_HALT=5'b11011
  - instruction field widths/positions (opcode [31:27], dest [26:22], src1 [21:17], mode [16], src2/imm)
  - HALT_INST, DEPTH/ADDR_W defaults
  - loader state encoding
- One sub-module: prog_loader_xor, a 16-bit XOR accumulator with clr and en inputs and an acc output.

Test Plan:
- Single instruction: start, header 0x0001, words 0x0841 and 0x0005, checksum 0x0845 -> one write addr 0 data 32'h0841_0005; then 15 HALT writes, addr 1..15 data 32'hD800_0000; done=1, cpu_rst=0, err=0.
- Full program: header 0x0010, 32 words, correct checksum -> 16 writes addr 0..15; no FILL writes; done=1.
- Bad checksum: same as the single-instruction case but checksum 0x0846 -> all writes occur, then err=1, done=0, cpu_rst stays 1.
- Bad header: header 0x0000 and 0x0011 in separate runs -> ERR right after the header; no im_we pulses; err=1.
- Backpressure/stall: in_valid toggled 1-0-1 randomly, start pulsed mid-load -> identical writes to the single-instruction case; start ignored; in_ready=0 in WRITE/FILL cycles.
- Reset mid-load: assert sys_rst after the 3rd word, asynchronously between edges -> outputs immediately at reset values, including cpu_rst=1; a new start and full load then succeeds.
